// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU datapath blocks.
//   ALU_WIDTH  : default operand/result width
//   ALUFN_ADD  : alufn encoding selecting A+B
//   ALUFN_SUB  : alufn encoding selecting A-B
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH = 16;

   localparam logic ALUFN_ADD = 1'b0;
   localparam logic ALUFN_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full adder, the cell of the ripple-carry chain in adder_sub.
// Ports:
//   a, b  : input bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// ---------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/adder_sub.sv
// ---------------------------------------------------------------------------
// adder_sub
// Registered two's-complement adder/subtractor with Z/V/N flags and carry
// out. One cycle of latency, a new operation accepted every clock.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset, clears all outputs
//   a, b    : operands (WIDTH bits)
//   alufn   : 0 = add (A+B), 1 = subtract (A-B)
//   result  : registered sum/difference modulo 2^WIDTH
//   w_cout  : registered carry out of the MSB (for subtract: 1 = no borrow)
//   z_out   : registered zero flag
//   v_out   : registered signed-overflow flag
//   n_out   : registered negative flag
// ---------------------------------------------------------------------------
module adder_sub
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             alufn,
   output logic [WIDTH-1:0] result,
   output logic             w_cout,
   output logic             z_out,
   output logic             v_out,
   output logic             n_out
);

   logic             is_sub;
   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] s;
   logic [WIDTH:0]   carry;
   logic             z;
   logic             v;
   logic             n;

   // Subtraction is A + ~B + 1: invert B and feed the +1 in as carry-in.
   assign is_sub   = (alufn == ALUFN_SUB);
   assign bx       = b ^ {WIDTH{is_sub}};
   assign carry[0] = is_sub;

   // Ripple-carry chain, one full adder per bit.
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_ripple
         full_adder u_fa (
            .a    (a[i]),
            .b    (bx[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
         );
      end
   endgenerate

   // Overflow uses the effective (possibly inverted) B operand: the adder
   // overflows when both addend signs agree and the sum sign differs.
   assign z = (s == '0);
   assign n = s[WIDTH-1];
   assign v = (a[WIDTH-1] & bx[WIDTH-1] & ~s[WIDTH-1]) |
              (~a[WIDTH-1] & ~bx[WIDTH-1] & s[WIDTH-1]);

   // Output register; reset discards any in-flight result immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         w_cout <= 1'b0;
         z_out  <= 1'b0;
         v_out  <= 1'b0;
         n_out  <= 1'b0;
      end else begin
         result <= s;
         w_cout <= carry[WIDTH];
         z_out  <= z;
         v_out  <= v;
         n_out  <= n;
      end
   end

endmodule : adder_sub

// File: tb/tb_adder_sub.sv
// ---------------------------------------------------------------------------
// tb_adder_sub
// Self-checking bench for adder_sub (WIDTH=16). Expected values come from an
// arithmetic model using integer add/subtract and signed range checks.
// ---------------------------------------------------------------------------
module tb_adder_sub;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         alufn;
   logic [W-1:0] result;
   logic         w_cout;
   logic         z_out;
   logic         v_out;
   logic         n_out;

   int errors = 0;
   int checks = 0;

   adder_sub #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .alufn  (alufn),
      .result (result),
      .w_cout (w_cout),
      .z_out  (z_out),
      .v_out  (v_out),
      .n_out  (n_out)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: packs {cout, z, v, n, result} from plain integer arithmetic.
   function automatic logic [W+3:0] model(input logic [W-1:0] ma,
                                          input logic [W-1:0] mb,
                                          input logic op);
      int ua, ub, sa, sb, full, trueval;
      logic [W-1:0] res;
      logic cout, zf, vf, nf;
      ua = int'({16'd0, ma});
      ub = int'({16'd0, mb});
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      if (op) begin
         full    = ua - ub;
         cout    = (ua >= ub);
         trueval = sa - sb;
      end else begin
         full    = ua + ub;
         cout    = (full > 65535);
         trueval = sa + sb;
      end
      res = full[W-1:0];
      zf  = (res == 0);
      nf  = res[W-1];
      vf  = (trueval > 32767) || (trueval < -32768);
      return {cout, zf, vf, nf, res};
   endfunction

   task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                              input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string step, input logic [W+3:0] exp);
      checkOutput({step, ".result"}, result, exp[W-1:0]);
      checkOutput({step, ".cout"}, {15'd0, w_cout}, {15'd0, exp[W+3]});
      checkOutput({step, ".z"}, {15'd0, z_out}, {15'd0, exp[W+2]});
      checkOutput({step, ".v"}, {15'd0, v_out}, {15'd0, exp[W+1]});
      checkOutput({step, ".n"}, {15'd0, n_out}, {15'd0, exp[W]});
   endtask

   // Drive on the falling edge, check 1 ns after the next rising edge.
   task automatic applyStimulus(input string step, input logic [W-1:0] sa,
                                input logic [W-1:0] sb, input logic op);
      @(negedge clk);
      a = sa;
      b = sb;
      alufn = op;
      @(posedge clk);
      #1;
      checkAll(step, model(sa, sb, op));
   endtask

   logic [W-1:0] corner [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

   initial begin
      logic [W-1:0] ra, rb;
      logic rop;

      rst_n = 1'b0;
      a = '0;
      b = '0;
      alufn = 1'b0;
      #2;
      checkAll("reset", '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      applyStimulus("sub_nob",  16'h0101, 16'h0011, 1'b1);
      applyStimulus("sub_bor",  16'hC0FF, 16'hEECC, 1'b1);
      applyStimulus("sub_msb",  16'hA234, 16'h8000, 1'b1);
      applyStimulus("sub_ovf",  16'h8000, 16'h0001, 1'b1);
      applyStimulus("add_zero", 16'hFFFF, 16'h0001, 1'b0);
      applyStimulus("add_neg",  16'hC0FF, 16'hEECC, 1'b0);
      applyStimulus("add_ovf",  16'h7FFF, 16'h0001, 1'b0);
      applyStimulus("sub_eq",   16'h1234, 16'h1234, 1'b1);

      // Spot-check the test-plan constants directly as well
      applyStimulus("plan_a", 16'hC0FF, 16'hEECC, 1'b1);
      checkOutput("plan_a.const", result, 16'hD233);
      applyStimulus("plan_b", 16'h7FFF, 16'h0001, 1'b0);
      checkOutput("plan_b.const", result, 16'h8000);

      // Asynchronous reset between edges while result is nonzero
      applyStimulus("pre_rst", 16'h1111, 16'h2222, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkAll("rst_async", '0);
      @(negedge clk);
      a = 16'h0F0F;
      b = 16'h0101;
      alufn = 1'b1;
      @(posedge clk);
      #1;
      checkAll("rst_hold", '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkAll("rst_rel", '0);
      @(posedge clk);
      #1;
      checkAll("rst_load", model(16'h0F0F, 16'h0101, 1'b1));

      // Randomized operations, biased toward corner operands
      for (int i = 0; i < 200; i++) begin
         ra  = $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 4)] : W'($urandom);
         rb  = $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 4)] : W'($urandom);
         rop = 1'($urandom);
         applyStimulus($sformatf("rand%0d", i), ra, rb, rop);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_adder_sub
